// File: rtl/pe_pkg.sv
// pe_pkg: shared types and defaults for the pe_mac processing element.
//   pe_state_e      - accumulator FSM states (IDLE, ACC, DRAIN)
//   PE_DW_DEFAULT   - default operand width
//   PE_ACCW_DEFAULT - default accumulator width
package pe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2
    } pe_state_e;

    localparam int PE_DW_DEFAULT   = 8;
    localparam int PE_ACCW_DEFAULT = 24;

endpackage

// File: rtl/pe_mac_if.sv
// pe_mac_if: operand/control bundle of one MAC processing element.
//   fire, in_w, in_a     - operand strobe and operands (upstream -> PE)
//   clear, drain         - accumulator control (upstream -> PE)
//   out_f, out_w, out_a  - registered forward to the downstream PE
//   psum, psum_valid     - drained result and its one-cycle qualifier
//   busy, ovf            - accumulator holds data / sticky overflow
// modport slave is the PE side, modport master the driving side.
interface pe_mac_if #(
    parameter int DW   = 8,
    parameter int ACCW = 24
);
    logic            fire;
    logic [DW-1:0]   in_w;
    logic [DW-1:0]   in_a;
    logic            clear;
    logic            drain;
    logic            out_f;
    logic [DW-1:0]   out_w;
    logic [DW-1:0]   out_a;
    logic [ACCW-1:0] psum;
    logic            psum_valid;
    logic            busy;
    logic            ovf;

    modport slave (
        input  fire, in_w, in_a, clear, drain,
        output out_f, out_w, out_a, psum, psum_valid, busy, ovf
    );

    modport master (
        output fire, in_w, in_a, clear, drain,
        input  out_f, out_w, out_a, psum, psum_valid, busy, ovf
    );
endinterface

// File: rtl/pe_mac_add.sv
// pe_mac_add: ACCW-bit accumulator adder with overflow detection.
//   a_i, b_i - addends (two's complement when SIGNED != 0, else unsigned)
//   sum_o    - result; wraps modulo 2^ACCW, or clamps to the type's
//              max/min when PE_MAC_SAT_EN is defined
//   ovf_o    - true sum not representable in ACCW bits
// Build option: `define PE_MAC_SAT_EN to enable saturation.
module pe_mac_add #(
    parameter int ACCW   = 24,
    parameter int SIGNED = 1
) (
    input  logic [ACCW-1:0] a_i,
    input  logic [ACCW-1:0] b_i,
    output logic [ACCW-1:0] sum_o,
    output logic            ovf_o
);

    logic [ACCW:0]   full;
    logic [ACCW-1:0] raw;

    assign full = {1'b0, a_i} + {1'b0, b_i};
    assign raw  = full[ACCW-1:0];

    always_comb begin
        if (SIGNED != 0) begin
            // Like-signed addends producing an opposite-signed result.
            ovf_o = (a_i[ACCW-1] == b_i[ACCW-1]) && (raw[ACCW-1] != a_i[ACCW-1]);
        end else begin
            ovf_o = full[ACCW];
        end
    end

`ifdef PE_MAC_SAT_EN
    always_comb begin
        sum_o = raw;
        if (ovf_o) begin
            if (SIGNED != 0) begin
                // Direction of overflow follows the (common) addend sign.
                sum_o = a_i[ACCW-1] ? {1'b1, {(ACCW-1){1'b0}}}
                                    : {1'b0, {(ACCW-1){1'b1}}};
            end else begin
                sum_o = {ACCW{1'b1}};
            end
        end
    end
`else
    assign sum_o = raw;
`endif

endmodule

// File: rtl/pe_mac.sv
// pe_mac: multiply-accumulate processing element for a systolic array.
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - pe_mac_if.slave: operands/controls in, forwarded operands,
//          drained psum/psum_valid, busy and sticky ovf out
// Build option: `define PE_MAC_SAT_EN for a saturating accumulator
// (default: wrap modulo 2^ACCW).
// ovf is sticky through an accumulation; clear wipes it, and drain
// restarts it with only the overflow of the drain cycle's own add.
module pe_mac
    import pe_pkg::*;
#(
    parameter int DW     = PE_DW_DEFAULT,
    parameter int ACCW   = PE_ACCW_DEFAULT,
    parameter int SIGNED = 1
) (
    input logic     clk,
    input logic     rst,
    pe_mac_if.slave bus
);

    if (ACCW < 2*DW) begin : g_chk
        $error("pe_mac: ACCW must be at least 2*DW");
    end

    pe_state_e       state_q, state_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic [ACCW-1:0] psum_q, psum_d;
    logic            pv_q, pv_d;
    logic            ovf_q, ovf_d;
    logic            of_q;
    logic [DW-1:0]   ow_q, oa_q;

    logic [ACCW-1:0] prod_ext;
    logic [ACCW-1:0] sum;
    logic            add_ovf;

    // Full-precision 2*DW product, then extended to the accumulator width.
    if (SIGNED != 0) begin : g_sprod
        logic signed [2*DW-1:0] p;
        assign p        = (2*DW)'($signed(bus.in_w)) * (2*DW)'($signed(bus.in_a));
        assign prod_ext = ACCW'(p);
    end else begin : g_uprod
        logic [2*DW-1:0] p;
        assign p        = (2*DW)'(bus.in_w) * (2*DW)'(bus.in_a);
        assign prod_ext = ACCW'(p);
    end

    pe_mac_add #(
        .ACCW   (ACCW),
        .SIGNED (SIGNED)
    ) u_add (
        .a_i   (acc_q),
        .b_i   (prod_ext),
        .sum_o (sum),
        .ovf_o (add_ovf)
    );

    // acc is zero whenever the FSM sits in IDLE or DRAIN, so acc+product
    // equals the product there and one adder serves every path.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        psum_d  = psum_q;
        pv_d    = 1'b0;
        ovf_d   = ovf_q;
        if (bus.clear) begin
            acc_d   = bus.fire ? prod_ext : '0;
            ovf_d   = 1'b0;
            state_d = bus.fire ? ACC : IDLE;
        end else if (bus.drain) begin
            psum_d  = bus.fire ? sum : acc_q;
            pv_d    = 1'b1;
            acc_d   = '0;
            ovf_d   = bus.fire & add_ovf;
            state_d = DRAIN;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.fire) begin
                        acc_d   = prod_ext;
                        state_d = ACC;
                    end
                end
                ACC: begin
                    if (bus.fire) begin
                        acc_d = sum;
                        ovf_d = ovf_q | add_ovf;
                    end
                end
                DRAIN: begin
                    acc_d   = bus.fire ? prod_ext : '0;
                    state_d = bus.fire ? ACC : IDLE;
                end
                default: begin
                    acc_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            psum_q  <= '0;
            pv_q    <= 1'b0;
            ovf_q   <= 1'b0;
            of_q    <= 1'b0;
            ow_q    <= '0;
            oa_q    <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            psum_q  <= psum_d;
            pv_q    <= pv_d;
            ovf_q   <= ovf_d;
            of_q    <= bus.fire;
            if (bus.fire) begin
                ow_q <= bus.in_w;
                oa_q <= bus.in_a;
            end
        end
    end

    assign bus.out_f      = of_q;
    assign bus.out_w      = ow_q;
    assign bus.out_a      = oa_q;
    assign bus.psum       = psum_q;
    assign bus.psum_valid = pv_q;
    assign bus.busy       = (state_q == ACC);
    assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_pe_mac.sv
// tb_pe_mac: self-checking bench for pe_mac. Three instances share one
// stimulus stream: unsigned 8/24, signed 8/24 and unsigned 8/16. Each
// test selects the instance it observes; drained results are predicted
// into a queue when drain is driven and popped when psum_valid appears.
module tb_pe_mac;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       fire, clear, drain;
    logic [7:0] in_w, in_a;

    pe_mac_if #(.DW(8), .ACCW(24)) ifu ();
    pe_mac_if #(.DW(8), .ACCW(24)) ifs ();
    pe_mac_if #(.DW(8), .ACCW(16)) ifn ();

    assign ifu.fire = fire;  assign ifu.in_w = in_w;  assign ifu.in_a = in_a;
    assign ifu.clear = clear; assign ifu.drain = drain;
    assign ifs.fire = fire;  assign ifs.in_w = in_w;  assign ifs.in_a = in_a;
    assign ifs.clear = clear; assign ifs.drain = drain;
    assign ifn.fire = fire;  assign ifn.in_w = in_w;  assign ifn.in_a = in_a;
    assign ifn.clear = clear; assign ifn.drain = drain;

    pe_mac #(.DW(8), .ACCW(24), .SIGNED(0)) dut_u (.clk(clk), .rst(rst), .bus(ifu.slave));
    pe_mac #(.DW(8), .ACCW(24), .SIGNED(1)) dut_s (.clk(clk), .rst(rst), .bus(ifs.slave));
    pe_mac #(.DW(8), .ACCW(16), .SIGNED(0)) dut_n (.clk(clk), .rst(rst), .bus(ifn.slave));

    int unsigned errors = 0;
    int unsigned checks = 0;
    int          sel    = 0;
    int unsigned pulses = 0;
    logic [23:0] sbq[$];

    logic [23:0] m_psum;
    logic        m_pv, m_busy, m_ovf, m_f;
    logic [7:0]  m_w, m_a;

    always_comb begin
        m_psum = ifu.psum; m_pv = ifu.psum_valid; m_busy = ifu.busy;
        m_ovf  = ifu.ovf;  m_f  = ifu.out_f; m_w = ifu.out_w; m_a = ifu.out_a;
        if (sel == 1) begin
            m_psum = ifs.psum; m_pv = ifs.psum_valid; m_busy = ifs.busy;
            m_ovf  = ifs.ovf;  m_f  = ifs.out_f; m_w = ifs.out_w; m_a = ifs.out_a;
        end else if (sel == 2) begin
            m_psum = {8'h00, ifn.psum}; m_pv = ifn.psum_valid; m_busy = ifn.busy;
            m_ovf  = ifn.ovf;  m_f  = ifn.out_f; m_w = ifn.out_w; m_a = ifn.out_a;
        end
    end

    // Scoreboard consumer: every psum_valid pulse must match a prediction.
    always @(negedge clk) begin
        if (m_pv === 1'b1) begin
            logic [23:0] exp;
            pulses++;
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_psum_valid: psum=%0h with no drain pending", m_psum);
            end else begin
                exp = sbq.pop_front();
                if (m_psum !== exp) begin
                    errors++;
                    $display("FAIL psum: got %0h expected %0h", m_psum, exp);
                end
            end
        end
    end

    task automatic cyc(input logic f, input logic [7:0] w, input logic [7:0] a,
                       input logic clr, input logic drn);
        fire = f; in_w = w; in_a = a; clear = clr; drain = drn;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic sb_empty(input string name);
        idle(2);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_psum: %0d drains produced no pulse", name, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic test_reset;
        sel = 0;
        rst = 1'b1;
        cyc(1'b1, 8'h12, 8'h34, 1'b0, 1'b1);
        cyc(1'b1, 8'h12, 8'h34, 1'b0, 1'b1);
        checks++;
        if ({m_psum, m_pv, m_busy, m_ovf, m_f, m_w, m_a} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: psum=%0h pv=%b busy=%b ovf=%b f=%b w=%0h a=%0h expected all 0",
                     m_psum, m_pv, m_busy, m_ovf, m_f, m_w, m_a);
        end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_accumulate;
        sel = 0;
        cyc(1'b1, 8'd2, 8'd3, 1'b0, 1'b0);
        checks++;
        if (m_a !== 8'd3 || m_f !== 1'b1) begin
            errors++;
            $display("FAIL fwd_first: out_a=%0d out_f=%b expected 3 1", m_a, m_f);
        end
        cyc(1'b1, 8'd4, 8'd5, 1'b0, 1'b0);
        checks++;
        if (m_a !== 8'd5 || m_w !== 8'd4) begin
            errors++;
            $display("FAIL fwd_second: out_w=%0d out_a=%0d expected 4 5", m_w, m_a);
        end
        cyc(1'b1, 8'd1, 8'd1, 1'b0, 1'b0);
        checks++;
        if (m_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_acc: got %b expected 1", m_busy);
        end
        sbq.push_back(24'd27);
        cyc(1'b0, 8'h63, 8'h63, 1'b0, 1'b1);
        checks++;
        if (m_busy !== 1'b0 || m_a !== 8'd1 || m_f !== 1'b0) begin
            errors++;
            $display("FAIL drain_state: busy=%b out_a=%0d out_f=%b expected 0 1 0", m_busy, m_a, m_f);
        end
        idle(2);
        checks++;
        if (m_psum !== 24'd27 || m_pv !== 1'b0) begin
            errors++;
            $display("FAIL psum_hold: psum=%0d pv=%b expected 27 0", m_psum, m_pv);
        end
        sb_empty("accumulate");
    endtask

    task automatic test_signed;
        sel = 1;
        cyc(1'b1, 8'hFD, 8'd4, 1'b0, 1'b0);
        cyc(1'b1, 8'd2, 8'hFB, 1'b0, 1'b0);
        sbq.push_back(24'hFFFFEA);
        cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        sb_empty("signed");
    endtask

    task automatic test_drain_fire;
        sel = 0;
        cyc(1'b1, 8'd2, 8'd5, 1'b0, 1'b0);
        sbq.push_back(24'd52);
        cyc(1'b1, 8'd6, 8'd7, 1'b0, 1'b1);
        cyc(1'b1, 8'd1, 8'd1, 1'b0, 1'b0);
        checks++;
        if (m_busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_from_drain: busy=%b expected 1", m_busy);
        end
        sbq.push_back(24'd1);
        cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        sb_empty("drain_fire");
    endtask

    task automatic test_back_to_back;
        int p0;
        sel = 0;
        p0 = pulses;
        cyc(1'b1, 8'd2, 8'd2, 1'b0, 1'b0);
        sbq.push_back(24'd4);
        cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        sbq.push_back(24'd9);
        cyc(1'b1, 8'd3, 8'd3, 1'b0, 1'b1);
        sbq.push_back(24'd0);
        cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        idle(1);
        // Drain from IDLE with no operand still pulses, with psum 0.
        sbq.push_back(24'd0);
        cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        sb_empty("back_to_back");
        checks++;
        if (pulses - p0 != 4) begin
            errors++;
            $display("FAIL b2b_pulse_count: got %0d expected 4", pulses - p0);
        end
    endtask

    task automatic test_clear;
        sel = 0;
        cyc(1'b1, 8'd10, 8'd10, 1'b0, 1'b0);
        cyc(1'b1, 8'd2, 8'd2, 1'b1, 1'b1);
        checks++;
        if (m_busy !== 1'b1 || m_pv !== 1'b0) begin
            errors++;
            $display("FAIL clear_state: busy=%b pv=%b expected 1 0", m_busy, m_pv);
        end
        sbq.push_back(24'd4);
        cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        sb_empty("clear");
    endtask

    task automatic test_overflow;
        sel = 2;
        cyc(1'b1, 8'd255, 8'd255, 1'b0, 1'b0);
        checks++;
        if (m_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_early: got %b expected 0", m_ovf);
        end
        cyc(1'b1, 8'd255, 8'd255, 1'b0, 1'b0);
        checks++;
        if (m_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: got %b expected 1", m_ovf);
        end
`ifdef PE_MAC_SAT_EN
        sbq.push_back(24'd65535);
`else
        sbq.push_back(24'd64514);
`endif
        cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        sb_empty("overflow");
    endtask

    task automatic test_rst_abort;
        sel = 0;
        cyc(1'b1, 8'd3, 8'd3, 1'b0, 1'b0);
        rst = 1'b1;
        cyc(1'b1, 8'd5, 8'd5, 1'b0, 1'b1);
        checks++;
        if ({m_psum, m_pv, m_busy, m_ovf, m_f, m_w, m_a} !== '0) begin
            errors++;
            $display("FAIL rst_abort: psum=%0h pv=%b busy=%b ovf=%b f=%b w=%0h a=%0h expected all 0",
                     m_psum, m_pv, m_busy, m_ovf, m_f, m_w, m_a);
        end
        rst = 1'b0;
        sb_empty("rst_abort");
    endtask

    initial begin
        rst = 1'b1; fire = 1'b0; clear = 1'b0; drain = 1'b0; in_w = '0; in_a = '0;
        test_reset();
        test_accumulate();
        test_signed();
        test_drain_fire();
        test_back_to_back();
        test_clear();
        test_overflow();
        test_rst_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pe_mac.md
PE_MAC -- requirements
Module: pe_mac

Interface
REQ-001 SHALL have parameter DW, default 8, operand width of in_w/in_a.
REQ-002 SHALL have parameter ACCW, default 24, accumulator width; ACCW >= 2*DW is required, with an elaboration error otherwise.
REQ-003 SHALL have parameter SIGNED, default 1; 1 = two's-complement operands, 0 = unsigned.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port fire, input, 1, operands valid this cycle.
REQ-007 SHALL have port in_w, input, DW, weight operand.
REQ-008 SHALL have port in_a, input, DW, activation operand.
REQ-009 SHALL have port clear, input, 1, discard accumulator.
REQ-010 SHALL have port drain, input, 1, emit accumulator and restart.
REQ-011 SHALL have port out_f, output, 1, registered copy of fire to the downstream PE.
REQ-012 SHALL have port out_w, output, DW, registered forward of in_w.
REQ-013 SHALL have port out_a, output, DW, registered forward of in_a.
REQ-014 SHALL have port psum, output, ACCW, drained result.
REQ-015 SHALL have port psum_valid, output, 1, one-cycle pulse qualifying psum.
REQ-016 SHALL have port busy, output, 1, high while the accumulator holds un-drained data.
REQ-017 SHALL have port ovf, output, 1, sticky overflow flag.

Function
REQ-018 SHALL form the product in_w*in_a at 2*DW bits, signed or unsigned per SIGNED, then sign- or zero-extend it to ACCW.
REQ-019 SHALL update out_f every cycle from fire; out_w and out_a SHALL load only when fire=1 and otherwise hold. Latency is 1 cycle.
REQ-020 SHALL implement the FSM states IDLE, ACC and DRAIN.
REQ-021 In IDLE with fire=1: acc <= product and the FSM SHALL move to ACC.
REQ-022 In ACC with fire=1: acc <= acc + product.
REQ-023 On drain=1 in IDLE or ACC: psum <= acc, plus product if fire=1; psum_valid SHALL be 1 in the next cycle; acc <= 0; the FSM SHALL move to DRAIN.
REQ-024 DRAIN SHALL last exactly one cycle. The FSM SHALL then go to IDLE, or to ACC if fire=1 during DRAIN; the operand in that cycle SHALL start the new accumulation.
REQ-025 drain asserted during DRAIN SHALL be honoured back-to-back; psum holds the operand accumulated in the DRAIN cycle, or 0.
REQ-026 clear SHALL take priority over drain: acc <= product if fire=1, else 0; no psum_valid; ovf cleared; next state ACC if fire=1, else IDLE.
REQ-027 drain in IDLE with fire=0 SHALL still pulse psum_valid with psum=0.
REQ-028 busy SHALL equal (state==ACC).
REQ-029 psum SHALL hold its value between drains.
REQ-030 Without saturation (see Configuration), accumulation SHALL wrap modulo 2^ACCW. ovf SHALL set when the true sum differs from the stored sum, and SHALL stay set until clear, drain or rst.

Reset
REQ-031 rst SHALL force state=IDLE, acc=0, psum=0, psum_valid=0, out_f=0, out_w=0, out_a=0 and ovf=0.
REQ-032 rst mid-accumulation or mid-DRAIN SHALL abort the operation without a psum_valid pulse.
REQ-033 rst SHALL override fire, clear and drain in the same cycle.

Configuration
REQ-034 Macro PE_MAC_SAT_EN defined: the accumulator SHALL saturate to the max/min of ACCW (signed or unsigned per SIGNED) on overflow, and ovf SHALL set.
REQ-035 PE_MAC_SAT_EN undefined: the accumulator SHALL wrap as in REQ-030, and no saturation logic SHALL be present.

Structure
REQ-036 Package pe_pkg SHALL hold the state enum (IDLE, ACC, DRAIN), PE_DW_DEFAULT=8 and PE_ACCW_DEFAULT=24.
REQ-037 Sub-module pe_mac_add SHALL perform the ACCW add with overflow detect and optional saturation, selected by PE_MAC_SAT_EN.

Verification
REQ-038 Test 1: DW=8, SIGNED=0; fire for 3 cycles with (w,a) = (2,3), (4,5), (1,1), then drain -> psum=27, psum_valid high for 1 cycle, busy falls, out_a trails in_a by 1 cycle.
REQ-039 Test 2: SIGNED=1; (w,a) = (-3,4), (2,-5), then drain -> psum=-22 as ACCW two's complement.
REQ-040 Test 3: drain together with fire (6,7) after acc=10 -> psum=52, acc=0; fire (1,1) during DRAIN -> a following drain gives psum=1.
REQ-041 Test 4: clear with fire (2,2) while acc=100 -> no psum_valid, acc=4; a following drain -> psum=4.
REQ-042 Test 5: ACCW=16, SIGNED=0; 255*255 accumulated twice -> with PE_MAC_SAT_EN psum=65535 and ovf=1; without it psum=64514 and ovf=1.
REQ-043 Test 6: rst asserted in ACC with drain=1 -> no psum_valid, all outputs 0 in the next cycle.
